// File: rtl/meter_pkg.sv
// Shared parking-meter constants: count width, ceiling, credit values and
// the loader FSM state type. Also used by the decrementer and display logic.
package meter_pkg;

    localparam int COUNT_W = 14;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 14'd9999;

    localparam logic [COUNT_W-1:0] INC_COIN0  = 14'd10;
    localparam logic [COUNT_W-1:0] INC_COIN1  = 14'd180;
    localparam logic [COUNT_W-1:0] INC_COIN2  = 14'd200;
    localparam logic [COUNT_W-1:0] INC_COIN3  = 14'd550;
    localparam logic [COUNT_W-1:0] PRESET_0   = 14'd10;
    localparam logic [COUNT_W-1:0] PRESET_1   = 14'd205;

    // Request slots, lowest index wins arbitration.
    localparam int N_REQ = 6;
    localparam logic [2:0] REQ_PRESET1 = 3'd0;
    localparam logic [2:0] REQ_PRESET0 = 3'd1;
    localparam logic [2:0] REQ_COIN0   = 3'd2;
    localparam logic [2:0] REQ_COIN1   = 3'd3;
    localparam logic [2:0] REQ_COIN2   = 3'd4;
    localparam logic [2:0] REQ_COIN3   = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUM   = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Credit constant associated with a request slot (increment or preset).
    function automatic logic [COUNT_W-1:0] req_const(input logic [2:0] idx);
        logic [COUNT_W-1:0] v;
        case (idx)
            REQ_PRESET1: v = PRESET_1;
            REQ_PRESET0: v = PRESET_0;
            REQ_COIN0:   v = INC_COIN0;
            REQ_COIN1:   v = INC_COIN1;
            REQ_COIN2:   v = INC_COIN2;
            REQ_COIN3:   v = INC_COIN3;
            default:     v = '0;
        endcase
        return v;
    endfunction

    function automatic logic req_is_preset(input logic [2:0] idx);
        return (idx == REQ_PRESET1) || (idx == REQ_PRESET0);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for one raw button plus a rising-edge pulse.
// The pulse is armed only after the synchronized input has been seen low
// once the chain is refilled after reset, so a button held through reset
// never reports a press.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic       r_armed;
    logic [1:0] r_fill;

    // Synchronizer chain, edge history and post-reset arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_meta  <= i_btn;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_fill  <= {r_fill[0], 1'b1};
            r_armed <= r_armed | (r_fill[1] & ~r_sync);
        end
    end

    assign o_rise = r_sync & ~r_prev & r_armed;

endmodule

// File: rtl/coin_loader.sv
// Credit-entry block: turns coin and preset presses into saturating writes
// of the remaining-time count.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | nothing pending, or picking the highest-priority request
//   SUM   | count_in sampled, result registered into count_out
//   WRITE | count_we high for one cycle
module coin_loader
    import meter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         btn_coin,
    input  logic [1:0]         btn_preset,
    input  logic [COUNT_W-1:0] count_in,
    output logic [COUNT_W-1:0] count_out,
    output logic               count_we,
    output logic               busy
);

    logic [N_REQ-1:0]   w_raw;
    logic [N_REQ-1:0]   w_rise;
    logic [N_REQ-1:0]   w_clear;
    logic [N_REQ-1:0]   r_pending;
    logic               w_any;
    logic [2:0]         w_win_idx;
    logic               w_grant;
    logic [2:0]         r_sel;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [COUNT_W:0]   w_sum;
    logic [COUNT_W-1:0] w_result;
    logic [COUNT_W-1:0] r_count_out;

    // Slot order matches arbitration priority.
    assign w_raw = {btn_coin, btn_preset[0], btn_preset[1]};

    for (genvar g = 0; g < N_REQ; g++) begin : g_sync
        btn_sync_edge u_sync (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (w_raw[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_any = |r_pending;

    // Fixed-priority pick: lowest pending index wins.
    always_comb begin
        w_win_idx = 3'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_win_idx = 3'(i);
            end
        end
    end

    // Next-state logic; the grant fires on the IDLE to SUM transition.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = SUM;
                    w_grant     = 1'b1;
                end
            end
            SUM:     w_state_nxt = WRITE;
            WRITE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_clear = w_grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx) : '0;

    // Pending requests: new edges merge with anything already waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_rise;
        end
    end

    // Remember which request is being serviced.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= 3'd0;
        end else if (w_grant) begin
            r_sel <= w_win_idx;
        end
    end

    // One extra bit on the add so the compare sees the true sum; an
    // out-of-range count_in also lands on the ceiling this way.
    always_comb begin
        w_sum    = {1'b0, count_in} + {1'b0, req_const(r_sel)};
        w_result = w_sum[COUNT_W-1:0];
        if (req_is_preset(r_sel)) begin
            w_result = req_const(r_sel);
        end else if (w_sum > {1'b0, COUNT_MAX}) begin
            w_result = COUNT_MAX;
        end
    end

    // Result captured in SUM and held until the next operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_out <= '0;
        end else if (r_state == SUM) begin
            r_count_out <= w_result;
        end
    end

    assign count_out = r_count_out;
    assign count_we  = (r_state == WRITE);
    assign busy      = (r_state != IDLE) || w_any;

endmodule

// File: tb/tb_coin_loader.sv
// Bench for coin_loader: directed cases plus randomized presses compared
// against a priority-list model of the expected write sequence.
module tb_coin_loader;
    import meter_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         btn_coin = '0;
    logic [1:0]         btn_preset = '0;
    logic [COUNT_W-1:0] count_in = '0;
    logic [COUNT_W-1:0] count_out;
    logic               count_we;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int sq_val[$];
    int sq_cyc[$];

    coin_loader dut (
        .clk        (clk),
        .rst        (rst),
        .btn_coin   (btn_coin),
        .btn_preset (btn_preset),
        .count_in   (count_in),
        .count_out  (count_out),
        .count_we   (count_we),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with the cycle it follows.
    always @(negedge clk) begin
        if (count_we) begin
            sq_val.push_back(int'(count_out));
            sq_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);
    endtask

    // mask bit order: 0=preset[1], 1=preset[0], 2..5=coin[0..3]
    task automatic press(input logic [5:0] mask, input int hold, output int start);
        sq_val.delete();
        sq_cyc.delete();
        btn_preset = {mask[0], mask[1]};
        btn_coin   = mask[5:2];
        start = cyc + 1;
        step(hold);
        btn_preset = '0;
        btn_coin   = '0;
    endtask

    function automatic int model_val(input int idx, input int cin);
        int inc;
        case (idx)
            0: return 205;
            1: return 10;
            2: inc = 10;
            3: inc = 180;
            4: inc = 200;
            default: inc = 550;
        endcase
        return (cin + inc > 9999) ? 9999 : cin + inc;
    endfunction

    task automatic check_writes(input string tag, input int start, input int exp[$]);
        int n;
        check({tag, "_nwr"}, sq_val.size(), exp.size());
        n = (sq_val.size() < exp.size()) ? sq_val.size() : exp.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_val%0d", tag, k), sq_val[k], exp[k]);
            check($sformatf("%s_cyc%0d", tag, k), sq_cyc[k] - start, 4 + 3 * k);
        end
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int s;
        int ev[$];

        do_reset();
        check("rst_out", int'(count_out), 0);
        check("rst_we", int'(count_we), 0);
        check("rst_busy", int'(busy), 0);

        // single coin held three cycles
        count_in = 14'd0;
        press(6'b001000, 3, s);
        step(25);
        ev = {180};
        check_writes("coin1", s, ev);

        // saturation
        count_in = 14'd9800;
        press(6'b100000, 1, s);
        step(20);
        ev = {9999};
        check_writes("sat9800", s, ev);
        count_in = 14'd9999;
        press(6'b000100, 2, s);
        step(20);
        ev = {9999};
        check_writes("sat9999", s, ev);

        // simultaneous preset[1] and coin[0]
        count_in = 14'd100;
        press(6'b000101, 1, s);
        step(25);
        ev = {205, 110};
        check_writes("prio", s, ev);

        // coin[2] pressed again while still pending behind preset[1]
        count_in = 14'd500;
        press(6'b010001, 1, s);
        step(1);
        btn_coin = 4'b0100;
        step(1);
        btn_coin = 4'b0000;
        step(25);
        ev = {205, 700};
        check_writes("merge", s, ev);

        // reset while in SUM
        count_in = 14'd50;
        press(6'b000100, 1, s);
        step(3);
        rst = 1'b1;
        step(2);
        check("abort_we", int'(count_we), 0);
        check("abort_out", int'(count_out), 0);
        check("abort_busy", int'(busy), 0);
        rst = 1'b0;
        step(30);
        check("abort_nwr", sq_val.size(), 0);

        // coin[0] held through reset release
        btn_coin = 4'b0001;
        step(2);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(20);
        check("held_nwr", sq_val.size(), 0);
        check("held_busy", int'(busy), 0);
        btn_coin = 4'b0000;
        step(8);
        check("held_rel_nwr", sq_val.size(), 0);
        press(6'b000100, 1, s);
        step(20);
        ev = {60};
        check_writes("after_held", s, ev);

        // illegal count_in and preset[0]
        count_in = 14'd12000;
        press(6'b000100, 1, s);
        step(20);
        ev = {9999};
        check_writes("illegal", s, ev);
        count_in = 14'($urandom_range(0, 16383));
        press(6'b000010, 1, s);
        step(20);
        ev = {10};
        check_writes("preset0", s, ev);

        // randomized presses
        for (int it = 0; it < 25; it++) begin
            logic [5:0] mask;
            int cin;
            int hold;
            mask = 6'($urandom_range(1, 63));
            hold = int'($urandom_range(1, 3));
            cin  = (it % 5 == 0) ? int'($urandom_range(9000, 10500))
                                 : int'($urandom_range(0, 9999));
            count_in = 14'(cin);
            ev.delete();
            for (int b = 0; b < 6; b++) begin
                if (mask[b]) ev.push_back(model_val(b, cin));
            end
            press(mask, hold, s);
            step(30);
            check_writes($sformatf("rnd%0d", it), s, ev);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/coin_loader.md
# coin_loader

Credit-entry block for the parking meter: turns raw coin and preset buttons into writes of new remaining-time values for the 14-bit seconds count. It is the writing side of the shared count, opposite the decrementer, which consumes time once per second. For each synchronized rising edge it computes a saturating sum (or a preset value) from the current count and issues a one-cycle write strobe to the count register owner.

## Interface
- `COUNT_W`, 14: width of the seconds count.
- `COUNT_MAX`, 9999: saturation ceiling in seconds.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_coin` input 4: raw asynchronous coin buttons. Bit 0 adds 10 s, bit 1 adds 180 s, bit 2 adds 200 s, bit 3 adds 550 s.
- `btn_preset` input 2: raw asynchronous preset buttons. Bit 0 loads 10 s, bit 1 loads 205 s.
- `count_in` input COUNT_W: current count from the register owner.
- `count_out` output COUNT_W: value to write.
- `count_we` output 1: one-cycle write strobe. The owner gives it priority over the decrementer's write in the same cycle.
- `busy` output 1: high whenever the FSM is not IDLE or any request is pending.

## Operation
- Each of the 6 raw inputs passes through a 2-FF synchronizer and then rising-edge detection. A detected edge sets that input's pending bit.
- If an edge arrives while the pending bit is already set, it merges and the credit is applied once.
- Arbitration in IDLE:
  - `btn_preset[1]` has highest priority, then `btn_preset[0]`, then `btn_coin[0]` up to `btn_coin[3]`.
  - The winner's pending bit clears on the transition out of IDLE.
  - Losing requests stay pending and are serviced in later passes.
- FSM states:
  - IDLE: no request pending, or choosing a winner. Goes to SUM when any pending bit is set.
  - SUM: registers the result. Always goes to WRITE.
  - WRITE: asserts `count_we`. Always goes to IDLE.
- Result rules:
  - Preset: the result is the preset constant; `count_in` is ignored.
  - Coin: the result is `min(count_in + inc, COUNT_MAX)`.
  - The add is computed at COUNT_W+1 bits, so no intermediate wrap is possible.
  - If `count_in` is above COUNT_MAX, which is illegal, the result is COUNT_MAX.
- `count_out` holds its last value outside WRITE. Only `count_we` qualifies it.
- Reset:
  - Synchronizers, edge registers and pending bits all clear. The FSM goes to IDLE.
  - Outputs reset to `count_out`=0, `count_we`=0, `busy`=0.
  - A reset in SUM or WRITE aborts the operation. No strobe is issued and the request is dropped.
  - A button held high through reset produces no edge after reset is released.

## Timing
- Raw input first sampled high at edge N. Synchronizer output is high after edge N+1. The pending bit is set at edge N+2.
- FSM is IDLE at edge N+2, enters SUM at N+3 (samples `count_in` during this cycle) and WRITE at N+4.
- `count_we` is high for exactly one cycle, between edges N+4 and N+5.
- Back-to-back pending requests produce strobes at least 3 cycles apart (IDLE, SUM, WRITE).
- A decrement landing between the SUM sample and WRITE is overwritten: at most one second is lost per credit. This is accepted.
- Raw inputs are debounced upstream by the slow-clock button logic. This block does not debounce.

## Structure
- Package `meter_pkg`:
  - COUNT_W and COUNT_MAX.
  - Increments 10, 180, 200, 550 and presets 10, 205 as named constants.
  - FSM state enum {IDLE, SUM, WRITE}.
  - Shared with the decrementer and the display logic.
- Sub-module `btn_sync_edge` (2-FF synchronizer plus registered rising-edge pulse), instantiated 6 times.
- Top level holds the pending register, fixed-priority arbiter, saturating adder and FSM.

## Test plan
- Reset, `count_in`=0, pulse `btn_coin[1]` for 3 cycles -> exactly one `count_we` with `count_out`=180, 4 edges after first sample. `busy` returns to 0.
- `count_in`=9800, pulse `btn_coin[3]` -> `count_out`=9999 (saturated). With `count_in`=9999 and `btn_coin[0]` -> 9999.
- `count_in`=100, raise `btn_coin[0]` and `btn_preset[1]` in the same cycle -> first strobe 205, second strobe `count_in`+10 exactly 3 cycles later. No third strobe.
- Raise `btn_coin[2]` twice while it is still pending -> a single +200 write.
- Assert `rst` during SUM -> no `count_we`, all outputs 0. Holding `btn_coin[0]` through reset release -> no strobe.
- `count_in`=12000 (illegal) plus `btn_coin[0]` -> `count_out`=9999. `btn_preset[0]` with any `count_in` -> 10.
